fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side controller for the team's synchronous FIFO. On a `start` command it drains exactly `len` words from the FIFO and presents them on a valid/ready output stream. It never asserts a read into an empty FIFO, so the FIFO's underflow flag never fires. A 2-entry output skid buffer absorbs the FIFO's one-cycle read latency and downstream backpressure, so throughput is one word per cycle when `m_ready` is held high.

## Interface
Parameters:
- WIDTH, 8, data width; must match the FIFO's WIDTH
- LEN_WIDTH, 4, width of burst length; maximum burst is 2^LEN_WIDTH-1 words

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  burst request; sampled only in IDLE
- len  in  LEN_WIDTH  burst length; sampled together with start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  single-cycle pulse at burst completion
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read enable
- fifo_rdata  in  WIDTH  FIFO read data; valid in the cycle after the edge that sampled fifo_rd_en=1
- m_valid  out  1  output word valid
- m_data  out  WIDTH  output word
- m_ready  in  1  downstream accept

## Operation
- FSM states:
  - IDLE: if start=1, load the issue counter and the output counter with len, then go to READ (len=0 goes to DONE instead).
  - READ: issue reads. When the issue counter reaches 0, go to DRAIN.
  - DRAIN: when the output counter reaches 0, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- fifo_rd_en is combinational from registered state and fifo_empty. It is 1 only when all of the following hold:
  - state is READ
  - issue counter != 0
  - fifo_empty = 0
  - (buffer occupancy + in-flight read − pop this cycle) < 2
- in-flight flag: set on each edge where fifo_rd_en=1. On the next edge, fifo_rdata is written into the skid buffer.
- Skid buffer:
  - 2 entries, FIFO order.
  - m_valid = occupancy != 0; m_data = head entry.
  - A pop occurs when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data is held stable.
- Counters:
  - The issue counter decrements on each fifo_rd_en; the output counter decrements on each pop.
  - Both are LEN_WIDTH unsigned and never wrap below 0.
- start or len changes outside IDLE are ignored.
- busy = (state != IDLE).
- Reset (asserted at any time, including mid-burst): state goes to IDLE, counters, buffer occupancy and in-flight flag are cleared, and all outputs go to 0 asynchronously. Words already read from the FIFO are discarded.

## Timing
- Reset values of every output: busy=0, done=0, fifo_rd_en=0, m_valid=0, m_data=0.
- start is sampled at edge E0. busy=1 after E0, and the first fifo_rd_en is possible in that same cycle.
- A rd_en sampled at edge Ek gives m_valid=1 after edge Ek+1 (2-edge latency from the read request).
- With m_ready=1 and the FIFO non-empty, fifo_rd_en is high for len consecutive cycles and m_valid is high for len consecutive cycles.
- done is high in the cycle after the edge where the last pop occurs; busy falls one cycle after done.
- len=0: done is high in the cycle after E0, with no fifo_rd_en.
- With m_ready=0 from the start of a burst, at most 2 reads are issued before fifo_rd_en stalls.
- fifo_empty rising stalls fifo_rd_en in the same cycle. Reads resume in the same cycle fifo_empty falls.

## Test plan
- FIFO preloaded 8'hA1..8'hA4, len=4, m_ready=1 -> 4 consecutive fifo_rd_en; m_data A1,A2,A3,A4 on consecutive cycles; done one cycle after the A4 pop; fifo_rd_en=0 thereafter.
- FIFO holds 8 words, len=6, m_ready=0 for 5 cycles then 1 -> exactly 2 fifo_rd_en during the stall; m_data stays at word 1; then 6 words are delivered in order; 2 words remain in the FIFO.
- FIFO empty, len=3; write 3 words spaced 4 cycles apart -> fifo_rd_en never high while fifo_empty=1; 3 words are delivered in order; done pulses; FIFO underflow stays 0.
- len=0 -> done=1 in the cycle after start; no fifo_rd_en; busy high for exactly 1 cycle.
- start pulsed with len=2 mid-burst of len=5 -> ignored; exactly 5 words are delivered and there is one done pulse.
- rst driven low mid-burst with 1 word buffered -> all outputs go to 0 immediately; after release the next start with len=15 (maximum) delivers 15 words and the counters do not wrap.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO: drains len words and
// streams them on a valid/ready port through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state, state_next;
    logic [LEN_WIDTH-1:0] issue_cnt, issue_next;
    logic [LEN_WIDTH-1:0] out_cnt, out_next;
    logic [1:0]           occ, occ_next, remaining;
    logic                 in_flight;
    logic [WIDTH-1:0]     ent0, ent1, ent0_next, ent1_next;
    logic                 pop;
    logic [2:0]           committed;

    assign m_valid = (occ != 2'd0);
    assign m_data  = ent0;
    assign pop     = m_valid && m_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Entries already held or on their way, minus the one leaving now; a new
    // read is only allowed if its word is guaranteed a slot.
    assign committed  = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
    assign fifo_rd_en = (state == READ) && (issue_cnt != '0) && !fifo_empty
                        && (committed < 3'd2);

    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        issue_next = issue_cnt;
        out_next   = out_cnt;
        if (pop && out_cnt != '0)
            out_next = out_cnt - 1'b1;
        if (fifo_rd_en)
            issue_next = issue_cnt - 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    issue_next = len;
                    out_next   = len;
                    state_next = (len == '0) ? DONE : READ;
                end
            end
            READ:    if (issue_next == '0) state_next = DRAIN;
            DRAIN:   if (out_next == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Head always lives in ent0; a pop shifts ent1 forward and the arriving
    // word lands in the first free slot after that shift.
    always_comb begin
        ent0_next = ent0;
        ent1_next = ent1;
        remaining = occ - {1'b0, pop};
        if (pop)
            ent0_next = ent1;
        if (in_flight) begin
            if (remaining == 2'd0)
                ent0_next = fifo_rdata;
            else
                ent1_next = fifo_rdata;
        end
        occ_next = remaining + {1'b0, in_flight};
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            out_cnt   <= '0;
            occ       <= 2'd0;
            in_flight <= 1'b0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_next;
            out_cnt   <= out_next;
            occ       <= occ_next;
            in_flight <= fifo_rd_en;
        end
    end

    // NOTE: the buffer entries are reset because ent0 drives m_data directly
    // and m_data must read 0 while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            ent0 <= ent0_next;
            ent1 <= ent1_next;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based FIFO feeds the DUT and
// every accepted output word is compared against the FIFO's write order.
module tb_fifo_burst_reader;

    localparam int WIDTH     = 8;
    localparam int LEN_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic                 busy, done;
    logic                 fifo_empty = 1'b1;
    logic                 fifo_rd_en;
    logic [WIDTH-1:0]     fifo_rdata = '0;
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic                 m_ready;

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model with registered empty flag and one-cycle read latency
    logic [WIDTH-1:0] fifo_q[$];
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    int               underflow = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) underflow++;
            else fifo_rdata <= fifo_q.pop_front();
        end
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Downstream ready: 0 = held low, 1 = held high, 2 = random
    int rdy_mode = 0;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Reference: every word written to the FIFO, in order; the DUT must emit
    // exactly this sequence.
    logic [WIDTH-1:0] model_fifo[$];

    int               rd_total = 0, del_total = 0, done_total = 0, rd_empty_viol = 0;
    logic             hold_q = 1'b0;
    logic [WIDTH-1:0] hold_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_q = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                rd_total++;
                if (fifo_empty) rd_empty_viol++;
            end
            if (done) done_total++;
            if (hold_q) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'(m_data), 32'(hold_data));
            end
            if (m_valid && m_ready) begin
                int avail;
                avail = model_fifo.size();
                check("scoreboard_nonempty", 32'(avail > 0), 32'd1);
                if (avail > 0) check("m_data", 32'(m_data), 32'(model_fifo.pop_front()));
                del_total++;
            end
            hold_q    = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        model_fifo.push_back(d);
        wait_clk(1);
        wr_en = 1'b0;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = LEN_WIDTH'(l);
        wait_clk(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
        wait_clk(1);
    endtask

    int rd_s, del_s, done_s;
    task automatic snap();
        rd_s   = rd_total;
        del_s  = del_total;
        done_s = done_total;
    endtask

    initial begin
        logic [WIDTH-1:0] w[$];
        int l, pre;

        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        #3 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        wait_clk(3);
        rst = 1'b1;
        wait_clk(1);

        // Back-to-back burst with exact cycle timing
        for (int i = 0; i < 4; i++) write_word(8'hA1 + 8'(i));
        rdy_mode = 1;
        wait_clk(1);
        snap();
        start_burst(4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_rd_en_c%0d", k), 32'(fifo_rd_en), 32'(k >= 1 && k <= 4));
            check($sformatf("t1_m_valid_c%0d", k), 32'(m_valid), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6)
                check($sformatf("t1_m_data_c%0d", k), 32'(m_data), 32'(8'hA1 + 8'(k - 3)));
            check($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 7));
            check($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 7));
        end
        wait_clk(1);
        check("t1_reads", 32'(rd_total - rd_s), 32'd4);
        check("t1_words", 32'(del_total - del_s), 32'd4);

        // Backpressure from the start of the burst
        rdy_mode = 0;
        w.delete();
        for (int i = 0; i < 8; i++) begin
            w.push_back(8'($urandom));
            write_word(w[i]);
        end
        wait_clk(1);
        snap();
        start_burst(6);
        repeat (5) @(negedge clk);
        check("t2_stall_reads", 32'(rd_total - rd_s), 32'd2);
        check("t2_stall_valid", 32'(m_valid), 32'd1);
        check("t2_stall_data", 32'(m_data), 32'(w[0]));
        wait_clk(1);
        rdy_mode = 1;
        wait_done("t2_done_seen", 100);
        check("t2_words", 32'(del_total - del_s), 32'd6);
        check("t2_fifo_left", 32'(fifo_q.size()), 32'd2);
        check("t2_model_left", 32'(model_fifo.size()), 32'd2);
        fifo_q.delete();
        model_fifo.delete();
        wait_clk(2);

        // Empty FIFO, words trickle in
        snap();
        start_burst(3);
        fork
            for (int i = 0; i < 3; i++) begin
                wait_clk(3);
                write_word(8'($urandom));
            end
            wait_done("t3_done_seen", 100);
        join
        check("t3_words", 32'(del_total - del_s), 32'd3);
        check("t3_done_pulses", 32'(done_total - done_s), 32'd1);
        check("t3_rd_while_empty", 32'(rd_empty_viol), 32'd0);
        check("t3_underflow", 32'(underflow), 32'd0);

        // Zero-length burst
        snap();
        start_burst(0);
        @(negedge clk);
        check("t4_done_c1", 32'(done), 32'd1);
        check("t4_busy_c1", 32'(busy), 32'd1);
        check("t4_rd_en_c1", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        check("t4_done_c2", 32'(done), 32'd0);
        check("t4_busy_c2", 32'(busy), 32'd0);
        wait_clk(1);
        check("t4_reads", 32'(rd_total - rd_s), 32'd0);

        // Start during a burst is ignored
        for (int i = 0; i < 5; i++) write_word(8'($urandom));
        wait_clk(1);
        snap();
        start_burst(5);
        wait_clk(1);
        start = 1'b1;
        len   = 4'd2;
        wait_clk(1);
        start = 1'b0;
        wait_done("t5_done_seen", 100);
        wait_clk(4);
        check("t5_words", 32'(del_total - del_s), 32'd5);
        check("t5_reads", 32'(rd_total - rd_s), 32'd5);
        check("t5_done_pulses", 32'(done_total - done_s), 32'd1);
        check("t5_busy_after", 32'(busy), 32'd0);

        // Reset mid-burst, then a maximum-length burst
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) write_word(8'($urandom));
        wait_clk(1);
        snap();
        start_burst(6);
        wait_clk(2);
        #1;
        check("t6_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_m_data", 32'(m_data), 32'd0);
        // Words the DUT had taken from the FIFO but not delivered are lost
        for (int i = 0; i < (rd_total - rd_s) - (del_total - del_s); i++)
            void'(model_fifo.pop_front());
        wait_clk(2);
        rst = 1'b1;
        wait_clk(1);
        for (int i = 0; i < 9; i++) write_word(8'($urandom));
        rdy_mode = 1;
        wait_clk(1);
        check("t6_fifo_fill", 32'(fifo_q.size()), 32'd15);
        snap();
        start_burst(15);
        wait_done("t6_done_seen", 200);
        wait_clk(3);
        check("t6_words", 32'(del_total - del_s), 32'd15);
        check("t6_reads", 32'(rd_total - rd_s), 32'd15);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("t6_underflow", 32'(underflow), 32'd0);

        // Randomized bursts with random backpressure and write timing
        rdy_mode = 2;
        for (int b = 0; b < 20; b++) begin
            l   = $urandom_range(0, 15);
            pre = $urandom_range(0, l);
            for (int i = 0; i < pre; i++) write_word(8'($urandom));
            snap();
            start_burst(l);
            fork
                for (int i = 0; i < l - pre; i++) begin
                    wait_clk($urandom_range(0, 3));
                    write_word(8'($urandom));
                end
                wait_done($sformatf("rand%0d_done_seen", b), 400);
            join
            check($sformatf("rand%0d_words", b), 32'(del_total - del_s), 32'(l));
            check($sformatf("rand%0d_reads", b), 32'(rd_total - rd_s), 32'(l));
        end
        check("rand_model_empty", 32'(model_fifo.size()), 32'd0);
        check("final_rd_while_empty", 32'(rd_empty_viol), 32'd0);
        check("final_underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
